exec_stage: RTL and testbench

EXEC_STAGE -- requirements
Module: exec_stage

---
 rtl/pebble_pkg.sv | 30 +++
 rtl/reg_file.sv | 40 ++++
 rtl/exec_stage.sv | 143 ++++++++++++++
 tb/tb_exec_stage.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/pebble_pkg.sv
// Shared types and constants for the pebble execute stage: datapath sizing,
// ALU opcodes, FSM states and instruction field positions.
package pebble_pkg;

  localparam int DW      = 8;
  localparam int NREG    = 8;
  localparam int REG_AW  = 3;
  localparam int INSTR_W = 9;

  localparam int OP_MSB   = 8;
  localparam int OP_LSB   = 7;
  localparam int MODE_BIT = 6;
  localparam int RD_MSB   = 5;
  localparam int RD_LSB   = 3;
  localparam int RB_MSB   = 2;
  localparam int RB_LSB   = 0;

  typedef enum logic [1:0] {
    ADD = 2'b00,
    SUB = 2'b01,
    AND = 2'b10,
    OR  = 2'b11
  } alu_op_t;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } exec_state_t;

endpackage

// File: rtl/reg_file.sv
// Register file: two combinational operand reads, one combinational debug read,
// one synchronous write port, synchronous clear.
module reg_file
  import pebble_pkg::*;
#(
  parameter int DW   = pebble_pkg::DW,
  parameter int NREG = pebble_pkg::NREG
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] raddr_a,
  input  logic [REG_AW-1:0] raddr_b,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DW-1:0]     rdata_a,
  output logic [DW-1:0]     rdata_b,
  output logic [DW-1:0]     dbg_data,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DW-1:0]     wdata
);

  logic [DW-1:0] regs_r [NREG];

  // Register storage; clear wins over any write on the same edge
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= {DW{1'b0}};
      end
    end else if (we) begin
      regs_r[waddr] <= wdata;
    end
  end

  // Reads see the stored value, so a same-cycle write is not forwarded
  assign rdata_a  = regs_r[raddr_a];
  assign rdata_b  = regs_r[raddr_b];
  assign dbg_data = regs_r[dbg_addr];

endmodule

// File: rtl/exec_stage.sv
// Execute stage: decodes ALU / LDI / NOP instructions, launches ALU ops for one
// EXEC cycle, writes results back into the register file and pulses done.
module exec_stage
  import pebble_pkg::*;
#(
  parameter int DW   = pebble_pkg::DW,
  parameter int NREG = pebble_pkg::NREG
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [INSTR_W-1:0] instr,
  output logic [1:0]         alu_opcode,
  output logic [DW-1:0]      alu_dat_a,
  output logic [DW-1:0]      alu_dat_b,
  input  logic [DW-1:0]      alu_result,
  input  logic               alu_zero,
  output logic               zero_flag,
  output logic               done,
  input  logic [REG_AW-1:0]  dbg_addr,
  output logic [DW-1:0]      dbg_data
);

  exec_state_t       state_r, state_next_s;
  logic              accept_s, is_alu_s, is_ldi_s, is_nop_s;
  logic [1:0]        op_s;
  logic [REG_AW-1:0] rd_s, rb_s, rd_r, waddr_s;
  logic [DW-1:0]     rdata_a_s, rdata_b_s, imm_s, wdata_s;
  logic              we_s;
  alu_op_t           alu_opcode_r;
  logic [DW-1:0]     dat_a_r, dat_b_r;
  logic              zero_flag_r, done_r;

  assign instr_ready = (state_r == IDLE) && !reset;
  assign accept_s    = instr_valid && instr_ready;
  assign op_s        = instr[OP_MSB:OP_LSB];
  assign rd_s        = instr[RD_MSB:RD_LSB];
  assign rb_s        = instr[RB_MSB:RB_LSB];
  assign imm_s       = {{(DW-3){1'b0}}, instr[RB_MSB:RB_LSB]};

  // Instruction class decode, qualified by the handshake
  always_comb begin
    is_alu_s = 1'b0;
    is_ldi_s = 1'b0;
    is_nop_s = 1'b0;
    if (accept_s) begin
      is_alu_s = !instr[MODE_BIT];
      is_ldi_s = instr[MODE_BIT] && (op_s == 2'b00);
      is_nop_s = instr[MODE_BIT] && (op_s != 2'b00);
    end else begin
      is_alu_s = 1'b0;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next state: only ALU ops spend a cycle in EXEC
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (is_alu_s) begin
          state_next_s = EXEC;
        end else begin
          state_next_s = IDLE;
        end
      end
      EXEC:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Write port select: ALU writeback in EXEC, immediate load at accept
  always_comb begin
    we_s    = 1'b0;
    waddr_s = rd_r;
    wdata_s = alu_result;
    if (state_r == EXEC) begin
      we_s = 1'b1;
    end else if (is_ldi_s) begin
      we_s    = 1'b1;
      waddr_s = rd_s;
      wdata_s = imm_s;
    end else begin
      we_s = 1'b0;
    end
  end

  // ALU operand latch, zero flag and retire pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_opcode_r <= ADD;
      dat_a_r      <= {DW{1'b0}};
      dat_b_r      <= {DW{1'b0}};
      rd_r         <= {REG_AW{1'b0}};
      zero_flag_r  <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      if (is_alu_s) begin
        alu_opcode_r <= alu_op_t'(op_s);
        dat_a_r      <= rdata_a_s;
        dat_b_r      <= rdata_b_s;
        rd_r         <= rd_s;
      end
      if (state_r == EXEC) begin
        zero_flag_r <= alu_zero;
      end
      done_r <= (state_r == EXEC) || is_ldi_s || is_nop_s;
    end
  end

  assign alu_opcode = alu_opcode_r;
  assign alu_dat_a  = dat_a_r;
  assign alu_dat_b  = dat_b_r;
  assign zero_flag  = zero_flag_r;
  assign done       = done_r;

  reg_file #(
    .DW   (DW),
    .NREG (NREG)
  ) u_reg_file (
    .clk      (clk),
    .reset    (reset),
    .raddr_a  (rd_s),
    .raddr_b  (rb_s),
    .dbg_addr (dbg_addr),
    .rdata_a  (rdata_a_s),
    .rdata_b  (rdata_b_s),
    .dbg_data (dbg_data),
    .we       (we_s),
    .waddr    (waddr_s),
    .wdata    (wdata_s)
  );

endmodule

// File: tb/tb_exec_stage.sv
// Directed bench for exec_stage with a behavioural ALU model attached to the
// ALU ports; every expected value is hand-computed.
module tb_exec_stage;

  logic       clk = 1'b0;
  logic       reset, instr_valid, instr_ready;
  logic [8:0] instr;
  logic [1:0] alu_opcode;
  logic [7:0] alu_dat_a, alu_dat_b, alu_result, dbg_data;
  logic       alu_zero, zero_flag, done;
  logic [2:0] dbg_addr;
  int         n_cmp = 0;
  int         n_bad = 0;

  exec_stage dut (
    .clk         (clk),
    .reset       (reset),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .alu_opcode  (alu_opcode),
    .alu_dat_a   (alu_dat_a),
    .alu_dat_b   (alu_dat_b),
    .alu_result  (alu_result),
    .alu_zero    (alu_zero),
    .zero_flag   (zero_flag),
    .done        (done),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  always #10 clk = ~clk;

  // Behavioural ALU
  always_comb begin
    case (alu_opcode)
      2'b00:   alu_result = alu_dat_a + alu_dat_b;
      2'b01:   alu_result = alu_dat_a - alu_dat_b;
      2'b10:   alu_result = alu_dat_a & alu_dat_b;
      default: alu_result = alu_dat_a | alu_dat_b;
    endcase
  end
  assign alu_zero = (alu_result == 8'h00);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dbg(input string tag, input logic [2:0] a, input logic [7:0] exp);
    dbg_addr = a;
    #1;
    chk(tag, {24'h0, dbg_data}, {24'h0, exp});
  endtask

  task automatic ldi(input logic [2:0] rd, input logic [2:0] imm);
    instr       = {2'b00, 1'b1, rd, imm};
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    chk("ldi_done", {31'h0, done}, 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] r0_exp;
    logic [7:0] wrap_tbl [6];
    wrap_tbl = '{8'd14, 8'd28, 8'd56, 8'd112, 8'd224, 8'd192};

    reset = 1'b1; instr_valid = 1'b0; instr = 9'h000; dbg_addr = 3'd0;
    tick(); tick();
    chk("rst_ready_low", {31'h0, instr_ready}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_zero", {31'h0, zero_flag}, 32'h0);
    chk("rst_opcode", {30'h0, alu_opcode}, 32'h0);
    chk("rst_dat_a", {24'h0, alu_dat_a}, 32'h0);
    chk("rst_dat_b", {24'h0, alu_dat_b}, 32'h0);
    dbg("rst_r3", 3'd3, 8'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_ready", {31'h0, instr_ready}, 32'h1);

    // LDI r3,5
    instr = 9'h05D; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    chk("ldi_r3_done", {31'h0, done}, 32'h1);
    dbg("ldi_r3_val", 3'd3, 8'd5);
    chk("ldi_r3_zero", {31'h0, zero_flag}, 32'h0);
    tick();
    chk("ldi_done_pulse_end", {31'h0, done}, 32'h0);

    // LDI r0,7; LDI r1,3; SUB r0,r1
    ldi(3'd0, 3'd7);
    ldi(3'd1, 3'd3);
    instr = 9'h081; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    chk("sub_exec_ready", {31'h0, instr_ready}, 32'h0);
    chk("sub_exec_done", {31'h0, done}, 32'h0);
    chk("sub_opcode", {30'h0, alu_opcode}, 32'h1);
    chk("sub_dat_a", {24'h0, alu_dat_a}, 32'd7);
    chk("sub_dat_b", {24'h0, alu_dat_b}, 32'd3);
    dbg("sub_prewrite_r0", 3'd0, 8'd7);
    tick();
    chk("sub_done", {31'h0, done}, 32'h1);
    dbg("sub_r0", 3'd0, 8'd4);
    chk("sub_zero", {31'h0, zero_flag}, 32'h0);
    chk("sub_hold_dat_a", {24'h0, alu_dat_a}, 32'd7);

    // ADD r0,r0 doubling with modulo wrap
    ldi(3'd0, 3'd7);
    r0_exp = 8'd7;
    for (int i = 0; i < 6; i++) begin
      instr = {2'b00, 1'b0, 3'd0, 3'd0}; instr_valid = 1'b1;
      tick();
      instr_valid = 1'b0;
      chk("add_exec_ready", {31'h0, instr_ready}, 32'h0);
      chk("add_same_operands", {24'h0, alu_dat_b}, {24'h0, r0_exp});
      chk("add_dat_a", {24'h0, alu_dat_a}, {24'h0, r0_exp});
      tick();
      r0_exp = wrap_tbl[i];
      dbg("add_r0", 3'd0, r0_exp);
    end

    // SUB r2,r2 sets the zero flag; a later LDI keeps it
    ldi(3'd2, 3'd6);
    instr = 9'h092; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    dbg("subz_r2", 3'd2, 8'd0);
    chk("subz_zero", {31'h0, zero_flag}, 32'h1);
    ldi(3'd4, 3'd1);
    chk("ldi_keeps_zero", {31'h0, zero_flag}, 32'h1);
    dbg("ldi_r4", 3'd4, 8'd1);

    // Reserved NOP changes nothing
    instr = 9'h1C0; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    chk("nop_done", {31'h0, done}, 32'h1);
    chk("nop_ready", {31'h0, instr_ready}, 32'h1);
    dbg("nop_r0", 3'd0, 8'd192);
    chk("nop_zero", {31'h0, zero_flag}, 32'h1);

    // Back-to-back ALU ops with instr_valid held high
    instr = {2'b00, 1'b0, 3'd1, 3'd0}; instr_valid = 1'b1;
    tick();
    chk("b2b1_ready", {31'h0, instr_ready}, 32'h0);
    chk("b2b1_dat_a", {24'h0, alu_dat_a}, 32'd3);
    chk("b2b1_dat_b", {24'h0, alu_dat_b}, 32'd192);
    chk("b2b1_done_low", {31'h0, done}, 32'h0);
    instr = {2'b11, 1'b0, 3'd5, 3'd1};
    tick();
    chk("b2b1_done", {31'h0, done}, 32'h1);
    dbg("b2b1_r1", 3'd1, 8'd195);
    chk("b2b1_zero", {31'h0, zero_flag}, 32'h0);
    tick();
    instr_valid = 1'b0;
    chk("b2b2_done_low", {31'h0, done}, 32'h0);
    chk("b2b2_ready", {31'h0, instr_ready}, 32'h0);
    chk("b2b2_opcode", {30'h0, alu_opcode}, 32'h3);
    chk("b2b2_dat_b", {24'h0, alu_dat_b}, 32'd195);
    tick();
    chk("b2b2_done", {31'h0, done}, 32'h1);
    dbg("b2b2_r5", 3'd5, 8'd195);
    tick();
    chk("b2b_no_dup_done", {31'h0, done}, 32'h0);
    dbg("b2b_no_dup_r1", 3'd1, 8'd195);

    // Reset during EXEC aborts the writeback
    instr = {2'b00, 1'b0, 3'd0, 3'd1}; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    reset = 1'b1;
    tick();
    chk("abort_ready_in_reset", {31'h0, instr_ready}, 32'h0);
    chk("abort_done", {31'h0, done}, 32'h0);
    reset = 1'b0;
    #1;
    chk("abort_ready", {31'h0, instr_ready}, 32'h1);
    chk("abort_zero", {31'h0, zero_flag}, 32'h0);
    chk("abort_dat_a", {24'h0, alu_dat_a}, 32'h0);
    for (int r = 0; r < 8; r++) begin
      dbg("abort_reg_clear", r[2:0], 8'd0);
    end
    tick();
    chk("abort_no_late_done", {31'h0, done}, 32'h0);
    dbg("abort_no_late_r0", 3'd0, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
